rf_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file and drives its RegWriteW/A3/WD inputs.
- Merges two writers: the in-order pipeline writeback (highest priority, never stalled) and a long-latency multiply/divide result stream (valid/ready), which is buffered in a small FIFO.
- Exposes pending-write lookups so decode can interlock on registers whose values are still buffered.

---
 rtl/rf_wb_arbiter_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/rf_wb_arbiter.sv | 91 +++++++++
 tb/tb_rf_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds the buffered-write record and the address-match helper used by the lookups.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // $0 never reports as pending, whatever the buffer holds.
    function automatic logic entry_hit(input wb_entry_t e, input logic occ,
                                       input logic [REG_ADDR_W-1:0] a);
        return occ && e.live && (a != REG_ZERO) && (e.addr == a);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of MDU results with per-entry live bits.
// Entries can be squashed by address; squashed entries still occupy a slot until popped.
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [REG_DATA_W-1:0] push_data,
    input  logic                  pop,
    input  logic                  squash_en,
    input  logic [REG_ADDR_W-1:0] squash_addr,
    input  logic [REG_ADDR_W-1:0] q1_addr,
    input  logic [REG_ADDR_W-1:0] q2_addr,
    output logic                  full,
    output logic                  head_occ,
    output logic                  head_live,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [REG_DATA_W-1:0] head_data,
    output logic                  q1_hit,
    output logic                  q2_hit
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] occ;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == (PW+1)'(DEPTH));
    assign push_ok   = push && !full;
    assign pop_ok    = pop && occ[rd_ptr];
    assign head_occ  = occ[rd_ptr];
    assign head_live = occ[rd_ptr] && mem[rd_ptr].live;
    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;

    always_comb begin
        q1_hit = 1'b0;
        q2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            q1_hit = q1_hit | entry_hit(mem[i], occ[i], q1_addr);
            q2_hit = q2_hit | entry_hit(mem[i], occ[i], q2_addr);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && occ[i] && (mem[i].addr == squash_addr))
                    mem[i].live <= 1'b0;
            end
            if (pop_ok) begin
                occ[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            // The slot being written is unoccupied, so a same-cycle squash never reaches it.
            if (push_ok) begin
                mem[wr_ptr] <= '{live: 1'b1, addr: push_addr, data: push_data};
                occ[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: pipeline writeback wins, buffered MDU results fill gaps.
// Also reports registers whose values are still sitting in the MDU buffer.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_DATA_W-1:0] wb_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_addr,
    input  logic [REG_DATA_W-1:0] mdu_data,
    input  logic [REG_ADDR_W-1:0] q1_addr,
    input  logic [REG_ADDR_W-1:0] q2_addr,
    output logic                  q1_pend,
    output logic                  q2_pend,
    output logic                  RegWriteW,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [REG_DATA_W-1:0] WD,
    output logic [CNTW-1:0]       conflict_cnt
);

    logic                  full;
    logic                  head_occ;
    logic                  head_live;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [REG_DATA_W-1:0] head_data;
    logic                  q1_hit;
    logic                  q2_hit;
    logic                  wb_claim;
    logic                  push;
    logic                  pop;

    assign wb_claim  = wb_we && (wb_addr != REG_ZERO);
    assign mdu_ready = !full && !reset;
    // A result for $0 is handshaken but dropped here.
    assign push      = mdu_valid && mdu_ready && (mdu_addr != REG_ZERO);
    assign pop       = !wb_claim && head_occ;
    assign q1_pend   = q1_hit && !reset;
    assign q2_pend   = q2_hit && !reset;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_addr  (mdu_addr),
        .push_data  (mdu_data),
        .pop        (pop),
        .squash_en  (wb_claim),
        .squash_addr(wb_addr),
        .q1_addr    (q1_addr),
        .q2_addr    (q2_addr),
        .full       (full),
        .head_occ   (head_occ),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .q1_hit     (q1_hit),
        .q2_hit     (q2_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW    <= 1'b0;
            A3           <= '0;
            WD           <= '0;
            conflict_cnt <= '0;
        end else begin
            if (wb_claim) begin
                RegWriteW <= 1'b1;
                A3        <= wb_addr;
                WD        <= wb_data;
                if (head_live && (conflict_cnt != {CNTW{1'b1}}))
                    conflict_cnt <= conflict_cnt + 1'b1;
            end else if (head_live) begin
                RegWriteW <= 1'b1;
                A3        <= head_addr;
                WD        <= head_data;
            end else begin
                // Squashed heads pop silently; A3/WD keep their last values.
                RegWriteW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: queue-based reference model checked every negedge,
// plus hand-computed literal expectations at key points of each scenario.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wb_we = 1'b0;
    logic [4:0]      wb_addr = '0;
    logic [31:0]     wb_data = '0;
    logic            mdu_valid = 1'b0;
    logic            mdu_ready;
    logic [4:0]      mdu_addr = '0;
    logic [31:0]     mdu_data = '0;
    logic [4:0]      q1_addr = '0;
    logic [4:0]      q2_addr = '0;
    logic            q1_pend;
    logic            q2_pend;
    logic            RegWriteW;
    logic [4:0]      A3;
    logic [31:0]     WD;
    logic [CNTW-1:0] conflict_cnt;

    int checks = 0;
    int failures = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_addr    (mdu_addr),
        .mdu_data    (mdu_data),
        .q1_addr     (q1_addr),
        .q2_addr     (q2_addr),
        .q1_pend     (q1_pend),
        .q2_pend     (q2_pend),
        .RegWriteW   (RegWriteW),
        .A3          (A3),
        .WD          (WD),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending MDU results as a plain queue, oldest first.
    typedef struct {
        bit          live;
        logic [4:0]  addr;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd = '0;
    int          m_cnt = 0;

    always @(posedge clk or posedge reset) begin
        bit    rdy;
        bit    hl;
        ment_t e;
        if (reset) begin
            mq.delete();
            m_we  = 1'b0;
            m_a3  = '0;
            m_wd  = '0;
            m_cnt = 0;
        end else begin
            rdy = (mq.size() < DEPTH);
            hl  = (mq.size() > 0) && mq[0].live;
            if (wb_we && wb_addr != 5'd0) begin
                m_we = 1'b1;
                m_a3 = wb_addr;
                m_wd = wb_data;
                if (hl && m_cnt < CMAX) m_cnt++;
                foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = e.live;
                if (e.live) begin
                    m_a3 = e.addr;
                    m_wd = e.data;
                end
            end else begin
                m_we = 1'b0;
            end
            if (mdu_valid && rdy && mdu_addr != 5'd0) begin
                e.live = 1'b1;
                e.addr = mdu_addr;
                e.data = mdu_data;
                mq.push_back(e);
            end
        end
    end

    function automatic logic exp_pend(input logic [4:0] a);
        if (reset || a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        chk("cmp_we", RegWriteW, m_we);
        chk("cmp_a3", A3, m_a3);
        chk("cmp_wd", WD, m_wd);
        chk("cmp_cnt", conflict_cnt, m_cnt);
        chk("cmp_ready", mdu_ready, !reset && (mq.size() < DEPTH));
        chk("cmp_q1_pend", q1_pend, exp_pend(q1_addr));
        chk("cmp_q2_pend", q2_pend, exp_pend(q2_addr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (3) step();
        chk("rst_ready_low", mdu_ready, 0);
        chk("rst_we", RegWriteW, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", mdu_ready, 1);
        chk("rst_a3", A3, 0);
        chk("rst_wd", WD, 0);
        chk("rst_cnt", conflict_cnt, 0);

        // Pipeline write: one cycle latency, then idle
        wb_we = 1; wb_addr = 8; wb_data = 32'h1234_5678;
        step();
        wb_we = 0;
        chk("wb_we", RegWriteW, 1);
        chk("wb_a3", A3, 8);
        chk("wb_wd", WD, 32'h1234_5678);
        step();
        chk("wb_we_off", RegWriteW, 0);
        chk("wb_a3_hold", A3, 8);

        // MDU drain: push, buffered, then written
        mdu_valid = 1; mdu_addr = 9; mdu_data = 32'hDEAD_BEEF; q1_addr = 9;
        step();
        mdu_valid = 0;
        chk("mdu_pend", q1_pend, 1);
        chk("mdu_no_bypass", RegWriteW, 0);
        step();
        chk("mdu_we", RegWriteW, 1);
        chk("mdu_a3", A3, 9);
        chk("mdu_wd", WD, 32'hDEAD_BEEF);
        chk("mdu_pend_clr", q1_pend, 0);
        step();
        chk("mdu_we_off", RegWriteW, 0);

        // Conflict and full
        wb_we = 1; wb_addr = 10; wb_data = 32'hA;
        mdu_valid = 1; mdu_addr = 3; mdu_data = 32'h33;
        step();
        mdu_addr = 4; mdu_data = 32'h44;
        step();
        mdu_valid = 0;
        chk("full_ready0", mdu_ready, 0);
        step();
        chk("full_ready1", mdu_ready, 0);
        step();
        chk("full_ready2", mdu_ready, 0);
        chk("conflict_3", conflict_cnt, 3);
        chk("conflict_a3", A3, 10);
        wb_we = 0;
        step();
        chk("drain_a3_3", A3, 3);
        chk("drain_wd_3", WD, 32'h33);
        step();
        chk("drain_a3_4", A3, 4);
        chk("drain_wd_4", WD, 32'h44);
        step();
        chk("drain_done", RegWriteW, 0);

        // Squash: buffered write to 5 superseded by pipeline write to 5
        mdu_valid = 1; mdu_addr = 5; mdu_data = 32'hAAAA; q1_addr = 5; q2_addr = 5;
        step();
        mdu_valid = 0;
        chk("sq_pend", q2_pend, 1);
        wb_we = 1; wb_addr = 5; wb_data = 32'h1;
        step();
        wb_we = 0;
        chk("sq_we", RegWriteW, 1);
        chk("sq_a3", A3, 5);
        chk("sq_wd", WD, 1);
        chk("sq_pend_clr", q1_pend, 0);
        chk("sq_cnt", conflict_cnt, 4);
        step();
        chk("sq_pop_silent", RegWriteW, 0);
        chk("sq_wd_hold", WD, 1);
        step();
        chk("sq_idle", RegWriteW, 0);

        // Register $0 from both writers
        wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
        mdu_valid = 1; mdu_addr = 0; mdu_data = 32'hBAD; q1_addr = 0;
        step();
        wb_we = 0; mdu_valid = 0;
        chk("zero_we", RegWriteW, 0);
        chk("zero_ready", mdu_ready, 1);
        chk("zero_pend", q1_pend, 0);
        step();
        chk("zero_no_drain", RegWriteW, 0);

        // Saturation of the conflict counter
        mdu_valid = 1; mdu_addr = 11; mdu_data = 32'hB;
        step();
        mdu_valid = 0;
        wb_we = 1; wb_addr = 12; wb_data = 32'hC;
        repeat (16) step();
        chk("sat_cnt", conflict_cnt, CMAX);
        wb_we = 0;
        step();
        chk("sat_drain_a3", A3, 11);
        step();

        // Reset mid-drain: second entry is lost
        mdu_valid = 1; mdu_addr = 7; mdu_data = 32'h7; q1_addr = 8;
        step();
        mdu_addr = 8; mdu_data = 32'h8;
        step();
        mdu_valid = 0;
        chk("mid_we", RegWriteW, 1);
        chk("mid_a3", A3, 7);
        chk("mid_pend8", q1_pend, 1);
        reset = 1;
        #1;
        chk("mid_rst_we", RegWriteW, 0);
        chk("mid_rst_a3", A3, 0);
        chk("mid_rst_cnt", conflict_cnt, 0);
        chk("mid_rst_ready", mdu_ready, 0);
        chk("mid_rst_pend", q1_pend, 0);
        step();
        reset = 0;
        step();
        chk("post_rst_pend", q1_pend, 0);
        chk("post_rst_we", RegWriteW, 0);
        step();
        chk("post_rst_lost", RegWriteW, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
